// File: rtl/temporizador_regressivo_pkg.sv
// Shared definitions for the down-counting timer.
//   estado_t          : FSM state encoding
//   largura_prescaler : bit width of the prescaler counter, ceil(log2(P)), min 1
package temporizador_regressivo_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    FIM      = 2'd3
  } estado_t;

  function automatic int largura_prescaler(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/temporizador_regressivo_divisor_tick.sv
// Prescaler for the timer: counts 0..PRESCALE-1 while enabled and wraps.
//   clock, reset_n : clock, synchronous active-low reset
//   habilita       : advance the count this edge
//   zera           : clear the count (wins over habilita)
//   tick           : high in the cycle whose edge wraps the count
module divisor_tick
  import temporizador_regressivo_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int W        = largura_prescaler(PRESCALE)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic habilita,
  input  logic zera,
  output logic tick
);

  localparam logic [W-1:0] ULTIMO = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = habilita && (cnt_q == ULTIMO);
    cnt_d = cnt_q;
    if (zera)          cnt_d = '0;
    else if (habilita) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/temporizador_regressivo.sv
// Loadable down-counting timer with start/pause/cancel and end-of-count pulse.
//   clock, reset_n : clock, synchronous active-low reset
//   inicia, valor  : start request and duration in count steps
//   pausa          : level, freezes the count while high
//   cancela        : abort back to idle, no end pulse
//   Q              : remaining count
//   ocupado        : counting or paused
//   meio           : counting/paused and Q equals half the loaded value
//   fim            : one-cycle end-of-count pulse
module temporizador_regressivo
  import temporizador_regressivo_pkg::*;
#(
  parameter int N        = 13,
  parameter int PRESCALE = 50
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inicia,
  input  logic [N-1:0] valor,
  input  logic         pausa,
  input  logic         cancela,
  output logic [N-1:0] Q,
  output logic         ocupado,
  output logic         meio,
  output logic         fim
);

  estado_t      estado_q, estado_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] valor_q, valor_d;
  logic         habilita, zera, tick;
  logic         ativo, parado;

  assign ativo  = (estado_q == CONTANDO) || (estado_q == PAUSADO);
  assign parado = (estado_q == OCIOSO) || (estado_q == FIM);

  // The prescaler advances on every edge of an active run where pausa is low,
  // including the edge that leaves PAUSADO, so each paused cycle costs
  // exactly one clock of delay.
  assign habilita = ativo && !pausa && !cancela;
  assign zera     = cancela || (parado && inicia);

  divisor_tick #(.PRESCALE(PRESCALE)) u_divisor (
    .clock    (clock),
    .reset_n  (reset_n),
    .habilita (habilita),
    .zera     (zera),
    .tick     (tick)
  );

  always_comb begin
    estado_d = estado_q;
    q_d      = q_q;
    valor_d  = valor_q;
    if (cancela) begin
      estado_d = OCIOSO;
      q_d      = '0;
    end else begin
      case (estado_q)
        OCIOSO, FIM: begin
          if (inicia) begin
            q_d      = valor;
            valor_d  = valor;
            estado_d = (valor == '0) ? FIM : CONTANDO;
          end else if (estado_q == FIM) begin
            estado_d = OCIOSO;
          end
        end
        default: begin
          if (pausa) begin
            estado_d = PAUSADO;
          end else begin
            estado_d = CONTANDO;
            if (tick && (q_q != '0)) begin
              q_d = q_q - 1'b1;
              if (q_q == N'(1)) estado_d = FIM;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      q_q      <= '0;
      valor_q  <= '0;
    end else begin
      estado_q <= estado_d;
      q_q      <= q_d;
      valor_q  <= valor_d;
    end
  end

  assign Q       = q_q;
  assign ocupado = ativo;
  assign meio    = ativo && (q_q == (valor_q >> 1));
  assign fim     = (estado_q == FIM);

endmodule

// File: tb/tb_temporizador_regressivo.sv
module tb_temporizador_regressivo;
  localparam int N = 8;
  localparam int P = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         inicia = 1'b0;
  logic         pausa = 1'b0;
  logic         cancela = 1'b0;
  logic [N-1:0] valor = '0;
  logic [N-1:0] Q;
  logic         ocupado, meio, fim;

  temporizador_regressivo #(.N(N), .PRESCALE(P)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .inicia  (inicia),
    .valor   (valor),
    .pausa   (pausa),
    .cancela (cancela),
    .Q       (Q),
    .ocupado (ocupado),
    .meio    (meio),
    .fim     (fim)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N+2:0] v;   // {Q, ocupado, meio, fim}
    string        nm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: every post-edge state the stimulus announced is checked at the
  // following falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({Q, ocupado, meio, fim} !== e.v) begin
        n_fail++;
        $display("FAIL %s: got Q=%0d ocupado=%b meio=%b fim=%b, expected Q=%0d ocupado=%b meio=%b fim=%b",
                 e.nm, Q, ocupado, meio, fim, e.v[N+2:3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  // Drive one edge and push the expected outputs after it. meio is expected
  // when busy and Q equals the loaded value (vst) halved.
  task automatic step(input logic ini, input logic [N-1:0] v, input logic pa,
                      input logic ca, input logic rn, input logic [N-1:0] eq,
                      input logic eo, input logic ef, input logic [N-1:0] vst,
                      input string nm);
    exp_t e;
    inicia = ini; valor = v; pausa = pa; cancela = ca; reset_n = rn;
    @(posedge clock);
    e.v  = {eq, eo, eo && (eq == (vst >> 1)), ef};
    e.nm = nm;
    sb.push_back(e);
    #1;
  endtask

  task automatic idle(input string nm);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0, nm);
  endtask

  // Start a run of v>=1 steps; pausa high on edges p_lo..p_hi, cancela on
  // edge c_at, a stray inicia (valor=9) on edge inj_at (edges counted from start).
  task automatic run(input int v, input int p_lo, input int p_hi,
                     input int c_at, input int inj_at, input string nm);
    int   adv;
    int   q;
    bit   done, pa, fx, ini;
    step(1'b1, N'(v), 1'b0, 1'b0, 1'b1, N'(v), 1'b1, 1'b0, N'(v), {nm, " start"});
    adv = 0; done = 0;
    for (int j = 1; !done && j < 200; j++) begin
      pa  = (j >= p_lo) && (j <= p_hi);
      ini = (j == inj_at);
      if (j == c_at) begin
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, '0, 1'b0, 1'b0, N'(v), $sformatf("%s cancel j=%0d", nm, j));
        done = 1;
      end else begin
        if (!pa) adv++;
        q  = v - adv / P;
        fx = (adv == v * P);
        step(ini, ini ? N'(9) : N'(0), pa, 1'b0, 1'b1, N'(q), !fx, fx, N'(v),
             $sformatf("%s j=%0d", nm, j));
        done = fx;
      end
    end
  endtask

  initial begin
    // Reset from power-up
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, "reset edge1");
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, "reset edge2");
    idle("post reset");

    // valor=5: Q 5..0 every 4 edges, meio at Q=2, ignored inicia at j=2
    run(5, 0, -1, -1, 2, "basic");
    idle("basic fim one cycle");

    // pausa high for edges 6..15: fim 10 clocks later
    run(5, 6, 15, -1, -1, "pause");
    idle("pause after");

    // cancela at edge 9, no fim afterwards, then a new start
    run(5, 0, -1, 9, -1, "cancel");
    for (int i = 0; i < 20; i++) idle($sformatf("after cancel %0d", i));
    run(3, 0, -1, -1, -1, "restart");
    idle("restart after");

    // valor=0: fim immediately, ocupado stays low; inicia in FIM restarts
    step(1'b1, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b1, '0, "valor0");
    run(2, 0, -1, -1, -1, "start in FIM");
    idle("fim restart after");
    step(1'b1, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b1, '0, "valor0 again");
    idle("valor0 one cycle");

    // cancela beats inicia in OCIOSO
    step(1'b1, N'(5), 1'b0, 1'b1, 1'b1, '0, 1'b0, 1'b0, '0, "cancela+inicia");
    idle("cancela+inicia after");

    // reset mid-count
    step(1'b1, N'(5), 1'b0, 1'b0, 1'b1, N'(5), 1'b1, 1'b0, N'(5), "mid start");
    for (int j = 1; j <= 5; j++)
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, N'(5 - j / P), 1'b1, 1'b0, N'(5), $sformatf("mid j=%0d", j));
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, "mid reset1");
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, "mid reset2");
    for (int i = 0; i < 24; i++) idle($sformatf("after mid reset %0d", i));

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/temporizador_regressivo.md
# temporizador_regressivo

Loadable down-counting timer with start/pause/cancel control and end-of-count pulse; the count-down counterpart of the team's modulo-M up-counter. Used by the drone control FSMs for programmable delays (motor spin-up, sensor timeouts, PWM hold intervals): the FSM loads a duration in ticks, starts it, and waits for `fim`. A shared prescaler stretches each count step to PRESCALE clocks.

## Interface
- `N`, 13: width of the count value and `Q`.
- `PRESCALE`, 50: clocks per count step (≥1); 50 gives 1 µs steps at 50 MHz.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `inicia`  in  1  start request; samples `valor`.
- `valor`  in  N  duration in count steps.
- `pausa`  in  1  level; freezes the count while high.
- `cancela`  in  1  abort; returns to idle without `fim`.
- `Q`  out  N  remaining count.
- `ocupado`  out  1  high in CONTANDO or PAUSADO.
- `meio`  out  1  high while CONTANDO/PAUSADO and `Q == valor_carregado>>1`.
- `fim`  out  1  one-cycle pulse when the count reaches zero.

## Operation
- States: OCIOSO, CONTANDO, PAUSADO, FIM. Moore outputs.
- Reset (`reset_n` low at an edge): state OCIOSO, `Q`=0, prescaler=0, stored value=0; `ocupado`=`meio`=`fim`=0.
- Priority per edge: reset > `cancela` > `inicia` > `pausa`.
- OCIOSO or FIM, `inicia`=1: `Q`←`valor`, store `valor`, prescaler←0; next state CONTANDO, or FIM if `valor`=0.
- `inicia` during CONTANDO/PAUSADO is ignored (no restart).
- CONTANDO: prescaler counts 0..PRESCALE-1 and wraps; on the wrap edge (tick), `Q`←`Q`-1. Tick with `Q`=1 → `Q`=0, next state FIM.
- `pausa`=1 in CONTANDO → PAUSADO; prescaler and `Q` hold. `pausa`=0 in PAUSADO → CONTANDO; the prescaler resumes from its held value.
- `cancela`=1 in CONTANDO/PAUSADO/FIM → OCIOSO, `Q`←0, prescaler←0; no `fim` is issued.
- FIM: `fim`=1 for exactly that cycle, then OCIOSO (unless `inicia` restarts).
- Arithmetic: unsigned N-bit; `Q` never decrements below 0. `meio` uses the stored value shifted right by one (valor=5 → `meio` at Q=2).

## Timing
- With start sampled at edge k and `valor`=V≥1: `Q`=V after k; decrements at edges k+PRESCALE·i; `Q`=0 and `fim` high after edge k+V·PRESCALE, for one cycle.
- `valor`=0: `fim` high in the cycle right after edge k.
- Each PAUSADO cycle delays `fim` by exactly one clock.
- `ocupado` rises the cycle after start and falls in the cycle `fim` rises.
- PRESCALE=1: one decrement per clock.

## Structure
- Shared package: state encoding (OCIOSO=0, CONTANDO=1, PAUSADO=2, FIM=3) and the width helper for the prescaler counter, ceil(log2(PRESCALE)) with a minimum of 1.
- Sub-module `divisor_tick`: prescaler with `habilita` and `zera` inputs and a `tick` output on the wrap cycle. The FSM and the `Q` register stay in the top module.

## Test plan
- With N=8 and PRESCALE=4.
- `reset_n`=0 for 2 edges mid-count → `Q`=0, `ocupado`=`meio`=`fim`=0, state OCIOSO on the next edge.
- `valor`=5, `inicia` at edge k → `Q` goes 5,4,3,2,1,0 at k, k+4, …, k+20; `meio` high for exactly 4 cycles at Q=2; `fim` high for one cycle after k+20.
- Same run with `pausa` high for 10 cycles starting at k+6 → `Q` frozen at 4 during the pause; `fim` after k+30.
- `cancela` at k+9 → `Q`=0 and `ocupado`=0 next cycle; `fim` never asserts; a new `inicia` is accepted afterward.
- `valor`=0 → `fim` for one cycle after k; `ocupado` never rises. `inicia` during CONTANDO with `valor`=9 → ignored, count continues from 5.
- `cancela` and `inicia` asserted together in OCIOSO → stays OCIOSO with `Q`=0.
